// File: rtl/argmax_classifier.sv
// argmax_classifier: collects one signed sum per class lane and reports the index and value of the largest.
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-low reset
//   In_result    NUM_CLASSES packed lanes of DATA_W signed sums, lane k at [DATA_W*k +: DATA_W]
//   In_valid     per-lane one-cycle capture strobe
//   Class_Out    index of the largest sum (lowest index on ties)
//   Max_Out      value of the largest sum
//   Output_Valid one-cycle pulse when Class_Out/Max_Out update
//   Timeout_Err  one-cycle pulse when an incomplete frame is abandoned
//   Overrun      one-cycle pulse when a strobe arrives while the bank is busy
module argmax_classifier #(
  parameter int NUM_CLASSES = 10,
  parameter int DATA_W = 26,
  parameter int TIMEOUT = 1023
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CLASSES*DATA_W-1:0] In_result,
  input  logic [NUM_CLASSES-1:0]        In_valid,
  output logic [3:0]                    Class_Out,
  output logic [DATA_W-1:0]             Max_Out,
  output logic                          Output_Valid,
  output logic                          Timeout_Err,
  output logic                          Overrun
);
  localparam int IW = $clog2(NUM_CLASSES);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, COLLECT, COMPARE, DONE} state_t;
  state_t state;
  logic signed [DATA_W-1:0] bank [NUM_CLASSES];
  logic [NUM_CLASSES-1:0] captured, next_mask;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx, best_idx;
  logic signed [DATA_W-1:0] best, cand;
  logic accepting, full_now, full_next, greater, last;
  always_comb begin
    accepting = state == IDLE || state == COLLECT;
    next_mask = captured | In_valid;
    full_now = &captured;
    full_next = &next_mask;
    cand = bank[idx];
    greater = cand > best;
    last = idx == IW'(NUM_CLASSES - 1);
  end
  // Strobes are only honoured while collecting and never during reset.
  always_ff @(posedge clk)
    if (rst && accepting)
      for (int k = 0; k < NUM_CLASSES; k++)
        if (In_valid[k]) bank[k] <= In_result[DATA_W*k +: DATA_W];
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      captured <= '0;
      cnt <= '0;
      idx <= '0;
      best_idx <= '0;
      best <= '0;
      Class_Out <= '0;
      Max_Out <= '0;
      Output_Valid <= 1'b0;
      Timeout_Err <= 1'b0;
      Overrun <= 1'b0;
    end else begin
      Output_Valid <= 1'b0;
      Timeout_Err <= 1'b0;
      Overrun <= !accepting && |In_valid;
      if (accepting) captured <= next_mask;
      // A mask already complete at this edge starts the scan seeded with lane 0.
      if (accepting && full_now) begin
        state <= COMPARE;
        best <= bank[0];
        best_idx <= '0;
        idx <= IW'(1);
      end else begin
        case (state)
          IDLE: begin
            cnt <= '0;
            if (|In_valid && !full_next) state <= COLLECT;
          end
          COLLECT: begin
            cnt <= cnt + 1'b1;
            // Completing the mask on the deadline edge wins over the timeout.
            if (!full_next && cnt == CW'(TIMEOUT - 1)) begin
              state <= IDLE;
              captured <= '0;
              Timeout_Err <= 1'b1;
            end
          end
          COMPARE: begin
            // Strict compare keeps the earliest index on ties.
            if (greater) begin
              best <= cand;
              best_idx <= idx;
            end
            if (last) begin
              Class_Out <= 4'(greater ? idx : best_idx);
              Max_Out <= greater ? cand : best;
              Output_Valid <= 1'b1;
              state <= DONE;
            end else
              idx <= idx + 1'b1;
          end
          default: begin
            state <= IDLE;
            captured <= '0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_argmax_classifier.sv
// tb_argmax_classifier: directed and randomized frames checked against an argmax reference model.
module tb_argmax_classifier;
  localparam int N = 10;
  localparam int W = 26;
  localparam int TO = 20;
  typedef logic signed [W-1:0] vec_t [N];
  logic clk = 1'b0;
  logic rst;
  logic [N*W-1:0] res;
  logic [N-1:0] vld;
  logic [3:0] class_out;
  logic [W-1:0] max_out;
  logic output_valid, timeout_err, overrun;
  int checks = 0;
  int errors = 0;
  argmax_classifier #(.NUM_CLASSES(N), .DATA_W(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .In_result(res), .In_valid(vld),
    .Class_Out(class_out), .Max_Out(max_out), .Output_Valid(output_valid),
    .Timeout_Err(timeout_err), .Overrun(overrun)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // Largest value first, then the first lane holding it.
  function automatic void model(input vec_t v, output int c, output logic [W-1:0] m);
    logic signed [W-1:0] b;
    b = v[0];
    foreach (v[i]) if (v[i] > b) b = v[i];
    c = -1;
    foreach (v[i]) if (c < 0 && v[i] == b) c = i;
    m = b;
  endfunction
  task automatic drive_lane(input int k, input logic [W-1:0] val);
    res[W*k +: W] = val;
    vld = N'(1) << k;
  endtask
  // Presents a whole frame; returns at #1 after the edge capturing the final lane.
  task automatic send(input vec_t v, input int mode);
    int perm [N];
    int p, g, t;
    if (mode == 0) begin
      for (int k = 0; k < N; k++) begin
        drive_lane(k, v[k]);
        tick();
      end
    end else if (mode == 1) begin
      for (int k = 0; k < N; k++) res[W*k +: W] = v[k];
      vld = '1;
      tick();
    end else begin
      for (int k = 0; k < N; k++) perm[k] = k;
      for (int k = N - 1; k > 0; k--) begin
        p = $urandom_range(k);
        t = perm[k]; perm[k] = perm[p]; perm[p] = t;
      end
      p = 0;
      while (p < N) begin
        g = $urandom_range(1, 3);
        vld = '0;
        for (int j = 0; j < g && p < N; j++) begin
          res[W*perm[p] +: W] = v[perm[p]];
          vld[perm[p]] = 1'b1;
          p++;
        end
        tick();
      end
    end
    vld = '0;
  endtask
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!output_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask
  task automatic check_result(input vec_t v, input string tag);
    int c;
    logic [W-1:0] m;
    model(v, c, m);
    chk({tag, "_class"}, class_out, c);
    chk({tag, "_max"}, max_out, m);
  endtask
  task automatic run_frame(input vec_t v, input int mode, input string tag);
    int lat;
    send(v, mode);
    wait_valid(lat);
    chk({tag, "_latency"}, lat, 10);
    check_result(v, tag);
    tick();
    chk({tag, "_valid_pulse"}, output_valid, 0);
    chk({tag, "_overrun_quiet"}, overrun, 0);
    check_result(v, {tag, "_hold"});
  endtask
  initial begin
    vec_t v;
    vec_t v2;
    int lat, at;
    logic seen, te;
    rst = 1'b0;
    res = '0;
    vld = '0;
    repeat (3) tick();
    chk("rst_class", class_out, 0);
    chk("rst_max", max_out, 0);
    chk("rst_valid", output_valid, 0);
    chk("rst_timeout", timeout_err, 0);
    chk("rst_overrun", overrun, 0);
    for (int k = 0; k < N; k++) res[W*k +: W] = W'($urandom);
    vld = '1;
    tick();
    vld = '0;
    rst = 1'b1;
    seen = 1'b0;
    repeat (14) begin
      tick();
      seen |= output_valid;
    end
    chk("no_capture_in_reset", seen, 0);
    for (int k = 0; k < N; k++) v[k] = W'(100 * (k + 1));
    run_frame(v, 0, "ramp");
    for (int k = 0; k < N; k++) v[k] = -W'(100);
    v[3] = -W'(5);
    run_frame(v, 1, "negative");
    chk("negative_hex", max_out, 26'h3FFFFFB);
    for (int k = 0; k < N; k++) v[k] = '0;
    v[2] = W'(500);
    v[7] = W'(500);
    run_frame(v, 2, "tie");
    for (int k = 0; k < N; k++) v[k] = W'(k * 7);
    drive_lane(5, W'(5000));
    tick();
    vld = '0;
    run_frame(v, 0, "overwrite");
    at = 0;
    seen = 1'b0;
    drive_lane(0, W'(9999));
    tick();
    for (int i = 1; i <= 40; i++) begin
      if (i <= 8) drive_lane(i, W'(9999));
      else vld = '0;
      tick();
      if (timeout_err && at == 0) at = i;
      seen |= output_valid;
    end
    chk("timeout_cycle", at, TO);
    chk("timeout_no_valid", seen, 0);
    for (int k = 0; k < N; k++) v[k] = W'(N - k);
    run_frame(v, 0, "after_timeout");
    for (int k = 0; k < N; k++) v[k] = W'(k * 3);
    v[6] = W'(77);
    te = 1'b0;
    drive_lane(0, v[0]);
    tick();
    for (int i = 1; i <= TO; i++) begin
      if (i <= 8) drive_lane(i, v[i]);
      else if (i == TO) drive_lane(9, v[9]);
      else vld = '0;
      tick();
      te |= timeout_err;
    end
    vld = '0;
    wait_valid(lat);
    te |= timeout_err;
    chk("precedence_latency", lat, 10);
    chk("precedence_no_timeout", te, 0);
    check_result(v, "precedence");
    tick();
    for (int k = 0; k < N; k++) v[k] = W'($urandom_range(0, 1000));
    v[8] = W'(2000);
    send(v, 1);
    tick();
    tick();
    drive_lane(4, W'(30000000));
    tick();
    vld = '0;
    chk("overrun_pulse", overrun, 1);
    wait_valid(lat);
    chk("overrun_latency", lat, 7);
    check_result(v, "overrun");
    tick();
    for (int k = 0; k < N; k++) v[k] = W'($urandom_range(0, 1000));
    send(v, 2);
    repeat (4) tick();
    rst = 1'b0;
    tick();
    chk("midreset_class", class_out, 0);
    chk("midreset_max", max_out, 0);
    chk("midreset_valid", output_valid, 0);
    rst = 1'b1;
    seen = 1'b0;
    repeat (15) begin
      tick();
      seen |= output_valid;
    end
    chk("midreset_no_valid", seen, 0);
    for (int f = 0; f < 8; f++) begin
      for (int k = 0; k < N; k++)
        v2[k] = $urandom_range(0, 1) ? W'($urandom) : W'(int'($urandom_range(0, 6)) - 3);
      run_frame(v2, f % 3, $sformatf("random%0d", f));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
